// File: rtl/rtc_pkg.sv
// Shared definitions for the ariane_rtc timer: register map, CTRL bit index, time type.
// The MSIP register is decoded only when RTC_IPI_EN is defined.
package rtc_pkg;

   typedef logic [63:0] rtc_time_t;

   localparam logic [15:0] ADDR_CTRL     = 16'h0000;
   localparam logic [15:0] ADDR_PRESCALE = 16'h0008;
   localparam logic [15:0] ADDR_MTIME    = 16'h0010;
   localparam logic [15:0] ADDR_MSIP     = 16'h0018;

   localparam int unsigned CTRL_EN_BIT = 0;

   typedef enum logic [2:0] {
      REG_CTRL,
      REG_PRESCALE,
      REG_MTIME,
      REG_MSIP,
      REG_NONE
   } rtc_reg_e;

   function automatic rtc_reg_e decode_addr(input logic [15:0] addr);
      rtc_reg_e sel;
      sel = REG_NONE;
      case (addr)
         ADDR_CTRL:     sel = REG_CTRL;
         ADDR_PRESCALE: sel = REG_PRESCALE;
         ADDR_MTIME:    sel = REG_MTIME;
`ifdef RTC_IPI_EN
         ADDR_MSIP:     sel = REG_MSIP;
`endif
         default:       sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Prescale counter: counts 0..limit while enabled, emits a one-cycle tick on reaching limit.
module rtc_prescaler #(
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  enable,
   input  logic [PRESCALE_W-1:0] limit,
   input  logic                  clear,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] count;

   assign tick = enable && (count == limit);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= tick ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/ariane_rtc.sv
// Memory-mapped RTC/CLINT-style timer for Ariane: CTRL, PRESCALE, MTIME, optional MSIP.
// Define RTC_IPI_EN to add the MSIP register and the ipi_o output.
module ariane_rtc
   import rtc_pkg::*;
#(
   parameter int unsigned PRESCALE_W     = 16,
   parameter int unsigned RESET_PRESCALE = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [15:0] addr_i,
   input  logic [63:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [63:0] rdata_o,
   input  logic [63:0] mtimecmp_i,
   output logic [63:0] time_o,
   output logic        time_irq_o
`ifdef RTC_IPI_EN
   ,
   output logic        ipi_o
`endif
);

   rtc_reg_e              sel;
   logic                  wr;
   logic                  enable;
   logic [PRESCALE_W-1:0] prescale;
   rtc_time_t             mtime;
   rtc_time_t             rd_val;
   logic                  tick;
   logic                  pre_clear;
`ifdef RTC_IPI_EN
   logic                  msip;
`endif

   assign sel       = decode_addr(addr_i);
   assign wr        = req_i && we_i;
   assign gnt_o     = req_i;
   assign time_o    = mtime;
   assign pre_clear = wr && ((sel == REG_PRESCALE) || (sel == REG_MTIME));

   rtc_prescaler #(
      .PRESCALE_W(PRESCALE_W)
   ) u_prescaler (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .enable(enable),
      .limit (prescale),
      .clear (pre_clear),
      .tick  (tick)
   );

   always_comb begin
      rd_val = '0;
      case (sel)
         REG_CTRL:     rd_val[CTRL_EN_BIT] = enable;
         REG_PRESCALE: rd_val[PRESCALE_W-1:0] = prescale;
         REG_MTIME:    rd_val = mtime;
`ifdef RTC_IPI_EN
         REG_MSIP:     rd_val[0] = msip;
`endif
         default:      rd_val = '0;
      endcase
   end

   // Read data is captured from pre-edge state, so a same-cycle write is not visible.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         enable     <= 1'b0;
         prescale   <= PRESCALE_W'(RESET_PRESCALE);
         mtime      <= '0;
         rvalid_o   <= 1'b0;
         rdata_o    <= '0;
         time_irq_o <= 1'b0;
      end else begin
         rvalid_o   <= req_i;
         rdata_o    <= (req_i && !we_i) ? rd_val : '0;
         time_irq_o <= (mtime >= mtimecmp_i);
         if (wr && (sel == REG_CTRL)) begin
            enable <= wdata_i[CTRL_EN_BIT];
         end
         if (wr && (sel == REG_PRESCALE)) begin
            prescale <= wdata_i[PRESCALE_W-1:0];
         end
         if (wr && (sel == REG_MTIME)) begin
            mtime <= wdata_i;
         end else if (tick) begin
            mtime <= mtime + 64'd1;
         end
      end
   end

`ifdef RTC_IPI_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         msip <= 1'b0;
      end else if (wr && (sel == REG_MSIP)) begin
         msip <= wdata_i[0];
      end
   end

   assign ipi_o = msip;
`endif

endmodule

// File: tb/tb_ariane_rtc.sv
// Self-checking bench for ariane_rtc: reference model plus response scoreboard.
// Honours RTC_IPI_EN the same way as the design.
module tb_ariane_rtc;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [15:0] addr_i = '0;
   logic [63:0] wdata_i = '0;
   logic [63:0] mtimecmp_i = '1;
   logic        gnt_o;
   logic        rvalid_o;
   logic [63:0] rdata_o;
   logic [63:0] time_o;
   logic        time_irq_o;
`ifdef RTC_IPI_EN
   logic        ipi_o;
`endif

   ariane_rtc #(
      .PRESCALE_W    (16),
      .RESET_PRESCALE(0)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .we_i      (we_i),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .gnt_o     (gnt_o),
      .rvalid_o  (rvalid_o),
      .rdata_o   (rdata_o),
      .mtimecmp_i(mtimecmp_i),
      .time_o    (time_o),
      .time_irq_o(time_irq_o)
`ifdef RTC_IPI_EN
      ,
      .ipi_o     (ipi_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [63:0] sb[$];

   // Reference state: enable flag, prescale limit, cycles since last tick, time, irq, msip.
   logic        m_en;
   logic [15:0] m_pre;
   int unsigned m_cnt;
   logic [63:0] m_time;
   logic        m_irq;
   logic        m_msip;

   logic [15:0] addrs [7] = '{16'h0000, 16'h0008, 16'h0010, 16'h0018, 16'h0020, 16'h0040, 16'h0011};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 1'b0; m_pre = 16'd0; m_cnt = 0; m_time = '0; m_irq = 1'b0; m_msip = 1'b0;
   endtask

   function automatic logic [63:0] model_read(input logic [15:0] addr);
      case (addr)
         16'h0000: return {63'd0, m_en};
         16'h0008: return {48'd0, m_pre};
         16'h0010: return m_time;
`ifdef RTC_IPI_EN
         16'h0018: return {63'd0, m_msip};
`endif
         default:  return 64'd0;
      endcase
   endfunction

   // One clock edge: time advances once every (PRESCALE+1) enabled cycles; writes override.
   task automatic model_step(input logic req, input logic we, input logic [15:0] addr,
                             input logic [63:0] wdata, input logic [63:0] cmp);
      if (req) sb.push_back(we ? 64'd0 : model_read(addr));
      m_irq = (m_time >= cmp);
      if (m_en) begin
         m_cnt = m_cnt + 1;
         if (m_cnt > int'(m_pre)) begin
            m_cnt = 0;
            m_time = m_time + 64'd1;
         end
      end
      if (req && we) begin
         case (addr)
            16'h0000: m_en = wdata[0];
            16'h0008: begin m_pre = wdata[15:0]; m_cnt = 0; end
            16'h0010: begin m_time = wdata; m_cnt = 0; end
`ifdef RTC_IPI_EN
            16'h0018: m_msip = wdata[0];
`endif
            default: ;
         endcase
      end
   endtask

   task automatic cycle(input logic req, input logic we, input logic [15:0] addr, input logic [63:0] wdata);
      req_i = req; we_i = we; addr_i = addr; wdata_i = wdata;
      @(posedge clk_i);
      model_step(req, we, addr, wdata, mtimecmp_i);
      #1;
      chk("time_o", time_o, m_time);
      chk("time_irq_o", {63'd0, time_irq_o}, {63'd0, m_irq});
`ifdef RTC_IPI_EN
      chk("ipi_o", {63'd0, ipi_o}, {63'd0, m_msip});
`endif
      req_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic wr(input logic [15:0] addr, input logic [63:0] data);
      cycle(1'b1, 1'b1, addr, data);
   endtask

   task automatic rd(input logic [15:0] addr);
      cycle(1'b1, 1'b0, addr, 64'd0);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 64'd0);
   endtask

   // Response monitor: every grant must produce exactly one rvalid pulse on the next cycle.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (rvalid_o) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL rvalid_o: got 1 expected 0 (no outstanding request)");
            end else begin
               chk("rdata_o", rdata_o, sb.pop_front());
            end
         end else if (sb.size() != 0) begin
            void'(sb.pop_front());
            n_cmp++; n_bad++;
            $display("FAIL rvalid_o: got 0 expected 1");
         end
      end
   end

   initial begin
      logic [63:0] t0;
      logic [63:0] wv;
      int unsigned guard;
      model_reset();

      // Reset state and combinational grant
      #12;
      chk("rst_time_o", time_o, 64'd0);
      chk("rst_irq", {63'd0, time_irq_o}, 64'd0);
      chk("rst_rvalid", {63'd0, rvalid_o}, 64'd0);
      req_i = 1'b1; #1;
      chk("gnt_hi", {63'd0, gnt_o}, 64'd1);
      req_i = 1'b0; #1;
      chk("gnt_lo", {63'd0, gnt_o}, 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // PRESCALE=0: one increment per cycle from 0
      rd(16'h0008);
      wr(16'h0000, 64'd1);
      for (int unsigned i = 1; i <= 8; i++) begin
         idle(1);
         chk("count_p0", time_o, 64'(i));
      end

      // PRESCALE=3: one increment every 4 cycles, then frozen while disabled
      wr(16'h0008, 64'd3);
      t0 = time_o;
      for (int unsigned i = 1; i <= 12; i++) begin
         idle(1);
         if (i % 4 == 0) chk("count_p3", time_o, t0 + 64'(i / 4));
      end
      wr(16'h0000, 64'd0);
      t0 = time_o;
      for (int unsigned i = 0; i < 10; i++) begin
         idle(1);
         chk("frozen", time_o, t0);
      end
      wr(16'h0000, 64'd1);
      idle(9);

      // Timer interrupt rise at 100, fall when threshold raised
      mtimecmp_i = 64'd100;
      wr(16'h0008, 64'd0);
      wr(16'h0010, 64'd0);
      guard = 0;
      while (time_o != 64'd100 && guard < 200) begin
         idle(1);
         guard++;
      end
      chk("reach_100", time_o, 64'd100);
      chk("irq_before", {63'd0, time_irq_o}, 64'd0);
      idle(1);
      chk("irq_rise", {63'd0, time_irq_o}, 64'd1);
      mtimecmp_i = 64'd200;
      idle(1);
      chk("irq_fall", {63'd0, time_irq_o}, 64'd0);

      // MTIME wrap at the top of the range
      mtimecmp_i = '1;
      wr(16'h0010, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("wr_top", time_o, 64'hFFFF_FFFF_FFFF_FFFE);
      idle(1);
      chk("irq_pre_top", {63'd0, time_irq_o}, 64'd0);
      idle(1);
      chk("wrap_zero", time_o, 64'd0);
      chk("irq_top", {63'd0, time_irq_o}, 64'd1);
      idle(1);
      chk("irq_after_wrap", {63'd0, time_irq_o}, 64'd0);

      // Register reads, unmapped read, write racing an increment
      rd(16'h0010);
      rd(16'h0040);
      rd(16'h0000);
      rd(16'h0018);
      wr(16'h0010, 64'h1234_5678_9ABC_DEF0);
      chk("wr_wins", time_o, 64'h1234_5678_9ABC_DEF0);
      rd(16'h0010);
      idle(2);

      // Randomized register traffic
      for (int unsigned i = 0; i < 400; i++) begin
         logic [15:0] a;
         logic        r;
         logic        w;
         if ($urandom_range(0, 7) == 0) mtimecmp_i = m_time + 64'($urandom_range(0, 20));
         a = addrs[$urandom_range(0, 6)];
         r = ($urandom_range(0, 2) != 0);
         w = $urandom_range(0, 1) != 0;
         wv = {$urandom, $urandom};
         if (a == 16'h0008) wv = 64'($urandom_range(0, 5));
         if (a == 16'h0000 && $urandom_range(0, 3) != 0) wv[0] = 1'b1;
         cycle(r, w, a, wv);
      end
      idle(2);

`ifdef RTC_IPI_EN
      wr(16'h0018, 64'd1);
      chk("ipi_set", {63'd0, ipi_o}, 64'd1);
      rd(16'h0018);
`endif

      // Reset asserted while a read response is in flight
      req_i = 1'b1; we_i = 1'b0; addr_i = 16'h0010;
      @(posedge clk_i);
      model_step(1'b1, 1'b0, 16'h0010, 64'd0, mtimecmp_i);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("rst_mid_rvalid", {63'd0, rvalid_o}, 64'd0);
      chk("rst_mid_time", time_o, 64'd0);
`ifdef RTC_IPI_EN
      chk("rst_mid_ipi", {63'd0, ipi_o}, 64'd0);
`endif
      sb.delete();
      model_reset();
      req_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #2;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("post_rst_rvalid", {63'd0, rvalid_o}, 64'd0);
      wr(16'h0000, 64'd1);
      idle(5);
      chk("post_rst_count", time_o, 64'd5);
      idle(2);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ariane_rtc.md
ARIANE_RTC -- requirements
Module: ariane_rtc

Interface
- REQ-001 SHALL have parameter PRESCALE_W, default 16, width of the prescale register and counter.
- REQ-002 SHALL have parameter RESET_PRESCALE, default 0, prescale register reset value.
- REQ-003 SHALL have port clk_i  input  1  single clock for all state.
- REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
- REQ-005 SHALL have port req_i  input  1  register access request.
- REQ-006 SHALL have port we_i  input  1  1 = write, 0 = read.
- REQ-007 SHALL have port addr_i  input  16  byte address of register.
- REQ-008 SHALL have port wdata_i  input  64  write data.
- REQ-009 SHALL have port gnt_o  output  1  request accepted.
- REQ-010 SHALL have port rvalid_o  output  1  response valid.
- REQ-011 SHALL have port rdata_o  output  64  read data.
- REQ-012 SHALL have port mtimecmp_i  input  64  compare threshold from the core's mtimecmp_o.
- REQ-013 SHALL have port time_o  output  64  global time, feeds core time_i.
- REQ-014 SHALL have port time_irq_o  output  1  timer interrupt, feeds core time_irq_i.
- REQ-015 SHALL have port ipi_o  output  1  inter-processor interrupt, feeds core ipi_i (present only with RTC_IPI_EN).

Function
- REQ-016 SHALL decode registers: 0x00 CTRL (bit0 = enable), 0x08 PRESCALE, 0x10 MTIME, 0x18 MSIP (bit0).
- REQ-017 SHALL drive gnt_o = req_i combinationally; every granted request completes, no back-pressure.
- REQ-018 SHALL pulse rvalid_o exactly one cycle after each granted request, reads and writes alike.
- REQ-019 SHALL return the register value sampled at grant on rdata_o with rvalid_o for reads; 0 for writes and unmapped reads.
- REQ-020 SHALL commit writes at the granting clock edge; unmapped writes ignored; unused register bits read 0.
- REQ-021 SHALL, while enable=1, count the prescaler 0..PRESCALE and on reaching PRESCALE wrap it to 0 and increment MTIME by 1 in the same edge.
- REQ-022 SHALL increment MTIME every cycle when PRESCALE = 0.
- REQ-023 SHALL freeze prescaler and MTIME while enable=0; re-enable resumes from the held prescaler value.
- REQ-024 SHALL clear the prescaler to 0 on any PRESCALE or MTIME write.
- REQ-025 SHALL give an MTIME write priority over a same-cycle increment; the written value appears on time_o next cycle.
- REQ-026 SHALL wrap MTIME from 0xFFFF_FFFF_FFFF_FFFF to 0.
- REQ-027 SHALL drive time_o directly from the MTIME register.
- REQ-028 SHALL register time_irq_o = (MTIME >= mtimecmp_i), unsigned 64-bit compare, one cycle latency, independent of enable.
- REQ-029 SHALL deassert time_irq_o one cycle after MTIME wraps below mtimecmp_i or mtimecmp_i is raised above MTIME.

Reset
- REQ-030 SHALL on rst_ni low asynchronously clear CTRL, MTIME, prescaler, MSIP, rvalid_o, rdata_o, time_irq_o, ipi_o, and load PRESCALE with RESET_PRESCALE.
- REQ-031 SHALL drop any in-flight response when reset is asserted mid-access; no rvalid_o after reset release for it.

Configuration
- REQ-032 SHALL, with RTC_IPI_EN defined, implement MSIP and drive ipi_o from its bit0 (registered, one cycle after write).
- REQ-033 SHALL, without RTC_IPI_EN, omit MSIP and ipi_o; address 0x18 behaves as unmapped.

Structure
- REQ-034 SHALL place register offsets, the CTRL bit index and the 64-bit time type in shared package rtc_pkg.
- REQ-035 SHALL implement the prescaler as sub-module rtc_prescaler (enable, limit, clear in; tick out).

Verification
- REQ-036 SHALL test: reset, write CTRL=1, PRESCALE=0 -> time_o increments 1 per cycle from 0.
- REQ-037 SHALL test: PRESCALE=3, enable -> MTIME increments every 4 cycles; disable for 10 cycles -> time_o constant.
- REQ-038 SHALL test: mtimecmp_i=100, enable, PRESCALE=0 -> time_irq_o rises the cycle after time_o reaches 100; mtimecmp_i=200 -> falls next cycle.
- REQ-039 SHALL test: write MTIME=0xFFFF_FFFF_FFFF_FFFE, mtimecmp_i=0xFFFF_FFFF_FFFF_FFFF -> irq asserts, MTIME wraps to 0, irq deasserts one cycle later.
- REQ-040 SHALL test: read 0x10 -> rvalid_o one cycle later with sampled MTIME; read 0x40 -> rdata_o 0; write MTIME during increment -> written value wins.
- REQ-041 SHALL test (RTC_IPI_EN): write MSIP=1 -> ipi_o high next cycle; rst_ni low mid-read -> ipi_o, rvalid_o 0 immediately.
